mul_sequencer: RTL and testbench

Multi-cycle multiply/accumulate sequencer for the processor's MUL, MLA and MLS instructions. It replaces single-cycle array multiplication with a radix-2 shift-add engine. It captures operands when the control unit issues a start, stalls the processor while iterating, and presents a registered result plus N/Z flags for one write-back cycle. It sits beside the ALU and is driven by the decoder's multiply-class ALUControl codes.

---
 rtl/mul_sequencer.sv | 150 +++++++++++++++
 tb/tb_mul_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Radix-2 shift-add multiply/accumulate engine for MUL, MLA and MLS.
//   Operands are captured on an accepted Start. The engine then iterates
//   WIDTH times, applies the accumulate step, and presents a registered
//   result for a single write-back cycle (DONE).
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   Start    request an operation (sampled in IDLE or DONE)
//   MulOp    00 MUL, 01 MLA, 10 MLS, 11 MUL
//   SrcA     multiplicand
//   SrcB     multiplier
//   SrcC     accumulator operand (MLA/MLS)
//   Busy     high in MULT and ACC
//   Stall    pipeline hold, combinational
//   Done     high for the single DONE cycle
//   Result   registered result, held until the next DONE
//   ResultN  Result[WIDTH-1], registered with Result
//   ResultZ  Result == 0, registered with Result
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] SrcC,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             ResultN,
  output logic             ResultZ
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MLA = 2'b01;
  localparam logic [1:0] OP_MLS = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] acc_val;

  always_comb begin
    case (op_q)
      OP_MLA:  acc_val = c_q + prod_q;
      OP_MLS:  acc_val = c_q - prod_q;
      default: acc_val = prod_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    op_d     = op_q;
    prod_d   = prod_q;
    count_d  = count_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          a_d     = SrcA;
          b_d     = SrcB;
          c_d     = SrcC;
          op_d    = MulOp;
          prod_d  = '0;
          count_d = '0;
          state_d = S_MULT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MULT: begin
        if (b_q[0]) begin
          prod_d = prod_q + a_q;
        end
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + CW'(1);
        // Count is sampled before increment, so the WIDTH-th iteration edge exits.
        if (count_q == LAST_ITER) begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        result_d = acc_val;
        n_d      = acc_val[WIDTH-1];
        z_d      = (acc_val == '0);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  assign Busy    = (state_q == S_MULT) || (state_q == S_ACC);
  assign Done    = (state_q == S_DONE);
  assign Stall   = ((state_q == S_IDLE) && Start) || Busy;
  assign Result  = result_q;
  assign ResultN = n_q;
  assign ResultZ = z_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: hand-computed results, cycle-accurate
// stall/done timing, ignored Start while busy, back-to-back chaining, and
// asynchronous reset abort.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MulOp = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] SrcC = '0;
  logic        Busy, Stall, Done;
  logic [31:0] Result;
  logic        ResultN, ResultZ;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MulOp  (MulOp),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .SrcC   (SrcC),
    .Busy   (Busy),
    .Stall  (Stall),
    .Done   (Done),
    .Result (Result),
    .ResultN(ResultN),
    .ResultZ(ResultZ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request for the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic exp_stall);
    MulOp = op;
    SrcA  = a;
    SrcB  = b;
    SrcC  = c;
    Start = 1'b1;
    #1;
    check("stall_start_cycle", Stall, 32'(exp_stall));
  endtask

  // Runs cycles 1..34 after the Start cycle and checks timing and result.
  task automatic wait_done(input string tag, input logic [31:0] exp, input logic expn,
                           input logic expz, input logic noise);
    int unsigned stall_n = 0;
    int unsigned done_n  = 0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      stall_n += 32'(Stall);
      done_n  += 32'(Done);
      if (cyc == 1) begin
        check({tag, "_busy"}, Busy, 32'd1);
        Start = 1'b0;
        SrcA  = $urandom;
        SrcB  = $urandom;
        SrcC  = $urandom;
        MulOp = 2'($urandom_range(0, 3));
      end
      if (noise && (cyc == 5 || cyc == 20)) begin
        Start = 1'b1;
        SrcA  = 32'd9;
        SrcB  = 32'd9;
        MulOp = 2'b00;
      end
      if (noise && (cyc == 6 || cyc == 21)) Start = 1'b0;
    end
    check({tag, "_stall_cycles"}, stall_n, 32'd33);
    check({tag, "_early_done"}, done_n, 32'd0);
    @(negedge clk);
    check({tag, "_done"}, Done, 32'd1);
    check({tag, "_stall_in_done"}, Stall, 32'd0);
    check({tag, "_result"}, Result, exp);
    check({tag, "_n"}, ResultN, 32'(expn));
    check({tag, "_z"}, ResultZ, 32'(expz));
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_idle_busy"}, Busy, 32'd0);
    check({tag, "_idle_done"}, Done, 32'd0);
    check({tag, "_idle_stall"}, Stall, 32'd0);
    check({tag, "_idle_hold"}, Result, exp);
  endtask

  initial begin
    int unsigned done_n;
    int unsigned busy_n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", Busy, 32'd0);
    check("rst_done", Done, 32'd0);
    check("rst_stall", Stall, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_n", ResultN, 32'd0);
    check("rst_z", ResultZ, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Basic operations
    issue(2'b00, 32'd7, 32'd6, 32'd0, 1'b1);
    wait_done("mul7x6", 32'd42, 1'b0, 1'b0, 1'b0);
    check_idle("mul7x6", 32'd42);

    issue(2'b01, 32'd3, 32'd4, 32'd10, 1'b1);
    wait_done("mla", 32'd22, 1'b0, 1'b0, 1'b0);
    check_idle("mla", 32'd22);

    // 10 - 12 wraps to -2
    issue(2'b10, 32'd3, 32'd4, 32'd10, 1'b1);
    wait_done("mls", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    check_idle("mls", 32'hFFFF_FFFE);

    // Wrap-around and boundary values
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    wait_done("mul_ff", 32'd1, 1'b0, 1'b0, 1'b0);
    check_idle("mul_ff", 32'd1);

    issue(2'b10, 32'd1, 32'd1, 32'd0, 1'b1);
    wait_done("mls_neg", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check_idle("mls_neg", 32'hFFFF_FFFF);

    issue(2'b11, 32'd0, 32'd5, 32'd77, 1'b1);
    wait_done("mul_zero", 32'd0, 1'b0, 1'b1, 1'b0);
    check_idle("mul_zero", 32'd0);

    // Start pulses while busy are ignored
    issue(2'b00, 32'd7, 32'd6, 32'd0, 1'b1);
    wait_done("noise", 32'd42, 1'b0, 1'b0, 1'b1);
    check_idle("noise", 32'd42);

    // Back-to-back: Start held in DONE, no IDLE gap
    issue(2'b00, 32'd7, 32'd6, 32'd0, 1'b1);
    wait_done("chain1", 32'd42, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 32'd2, 32'd3, 32'd0, 1'b0);
    wait_done("chain2", 32'd6, 1'b0, 1'b0, 1'b0);
    check_idle("chain2", 32'd6);

    // Asynchronous reset mid-operation
    issue(2'b01, 32'd3, 32'd4, 32'd10, 1'b1);
    repeat (10) @(negedge clk);
    Start = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", Busy, 32'd0);
    check("arst_done", Done, 32'd0);
    check("arst_result", Result, 32'd0);
    check("arst_z", ResultZ, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_n += 32'(Done);
      busy_n += 32'(Busy);
    end
    check("arst_no_done", done_n, 32'd0);
    check("arst_no_busy", busy_n, 32'd0);
    check("arst_result_hold", Result, 32'd0);

    issue(2'b00, 32'd5, 32'd5, 32'd0, 1'b1);
    wait_done("mul5x5", 32'd25, 1'b0, 1'b0, 1'b0);
    check_idle("mul5x5", 32'd25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
